// File: rtl/ttt_pkg.sv
// Shared definitions for the TTT event collector: event codes and the
// buffered event record layout.
package ttt_pkg;

    localparam logic [1:0] NONE    = 2'b00;
    localparam logic [1:0] STOP    = 2'b01;
    localparam logic [1:0] START   = 2'b10;
    localparam logic [1:0] RESTART = 2'b11;

    // Fields are sized for the widest supported configuration; narrower
    // builds zero-extend into them and the constant upper bits fold away.
    localparam int REC_ID_BITS = 8;
    localparam int REC_TS_BITS = 32;

    typedef struct packed {
        logic [REC_ID_BITS-1:0] id;
        logic [1:0]             code;
        logic [REC_TS_BITS-1:0] ts;
    } evt_rec_t;

endpackage

// File: rtl/ttt_event_fifo.sv
// First-word fall-through event buffer. Accepts a push while full only when
// a pop retires the head in the same cycle.
module ttt_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;
    // Head reads as zero while empty so the host never sees stale contents.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ttt_event_collector.sv
// Captures start/stop/restart events from the core, timestamps them and
// buffers them for the host; also tracks which processors are active.
module ttt_event_collector
    import ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS = 10,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMESTAMP_BITS = 16
) (
    input  logic                              clock_fast,
    input  logic                              reset,
    input  logic                              output_valid,
    input  logic [$clog2(NUM_PROCESSORS)-1:0] processor_id_out,
    input  logic [1:0]                        token_startstop,
    output logic                              evt_valid,
    input  logic                              evt_ready,
    output logic [$clog2(NUM_PROCESSORS)-1:0] evt_processor_id,
    output logic [1:0]                        evt_code,
    output logic [TIMESTAMP_BITS-1:0]         evt_timestamp,
    output logic [NUM_PROCESSORS-1:0]         active_mask,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
    output logic                              overflow,
    output logic                              id_error,
    input  logic                              clear_flags
);

    localparam int ID_W = $clog2(NUM_PROCESSORS);

    logic [TIMESTAMP_BITS-1:0] timestamp;
    logic                      event_seen;
    logic                      id_in_range;
    logic                      capture;
    logic                      id_bad;
    logic                      pop_fire;
    logic                      drop;
    logic                      fifo_full;
    logic                      fifo_empty;
    evt_rec_t                  push_rec;
    evt_rec_t                  head_rec;
    logic [NUM_PROCESSORS-1:0] mask_next;

    // Extra bit keeps the range check valid when NUM_PROCESSORS is 2^ID_W.
    assign id_in_range = ({1'b0, processor_id_out} < (ID_W+1)'(NUM_PROCESSORS));
    assign event_seen  = output_valid && (token_startstop != NONE);
    assign capture     = event_seen && id_in_range;
    assign id_bad      = event_seen && !id_in_range;

    // Host handshake: evt_valid means the head entry is presented on evt_*;
    // it is consumed on a rising edge where evt_valid and evt_ready are both
    // high, and the head holds steady while evt_valid=1 and evt_ready=0.
    assign pop_fire  = evt_valid && evt_ready;
    assign drop      = capture && fifo_full && !pop_fire;
    assign evt_valid = !fifo_empty;

    always_comb begin
        push_rec      = '0;
        push_rec.id   = REC_ID_BITS'(processor_id_out);
        push_rec.code = token_startstop;
        push_rec.ts   = REC_TS_BITS'(timestamp);
    end

    ttt_event_fifo #(
        .WIDTH ($bits(evt_rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clock_fast),
        .rst   (reset),
        .push  (capture),
        .pop   (evt_ready),
        .din   (push_rec),
        .dout  (head_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign evt_processor_id = ID_W'(head_rec.id);
    assign evt_code         = head_rec.code;
    assign evt_timestamp    = TIMESTAMP_BITS'(head_rec.ts);

    // Mask follows every in-range capture, even one the full buffer drops.
    always_comb begin
        mask_next = active_mask;
        for (int i = 0; i < NUM_PROCESSORS; i++) begin
            if (capture && (processor_id_out == ID_W'(i))) begin
                mask_next[i] = (token_startstop != STOP);
            end
        end
    end

    always_ff @(posedge clock_fast or posedge reset) begin
        if (reset) begin
            timestamp   <= '0;
            active_mask <= '0;
            overflow    <= 1'b0;
            id_error    <= 1'b0;
        end else begin
            timestamp   <= timestamp + TIMESTAMP_BITS'(1);
            active_mask <= mask_next;
            if (drop)             overflow <= 1'b1;
            else if (clear_flags) overflow <= 1'b0;
            if (id_bad)           id_error <= 1'b1;
            else if (clear_flags) id_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ttt_event_collector.sv
// Scoreboard bench for ttt_event_collector: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_ttt_event_collector;

  localparam int NP  = 10;
  localparam int FD  = 8;
  localparam int TSB = 16;

  logic        clock_fast = 1'b0;
  logic        reset = 1'b1;
  logic        output_valid = 1'b0;
  logic [3:0]  processor_id_out = '0;
  logic [1:0]  token_startstop = '0;
  logic        evt_ready = 1'b0;
  logic        clear_flags = 1'b0;
  logic        evt_valid;
  logic [3:0]  evt_processor_id;
  logic [1:0]  evt_code;
  logic [15:0] evt_timestamp;
  logic [9:0]  active_mask;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        id_error;

  ttt_event_collector #(
    .NUM_PROCESSORS (NP),
    .FIFO_DEPTH     (FD),
    .TIMESTAMP_BITS (TSB)
  ) dut (
    .clock_fast       (clock_fast),
    .reset            (reset),
    .output_valid     (output_valid),
    .processor_id_out (processor_id_out),
    .token_startstop  (token_startstop),
    .evt_valid        (evt_valid),
    .evt_ready        (evt_ready),
    .evt_processor_id (evt_processor_id),
    .evt_code         (evt_code),
    .evt_timestamp    (evt_timestamp),
    .active_mask      (active_mask),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .id_error         (id_error),
    .clear_flags      (clear_flags)
  );

  // clock / reset
  always #5 clock_fast = ~clock_fast;

  int checks = 0;
  int passes = 0;

  // reference model state: queue entries are {id, code, timestamp}
  logic [21:0] exp_q[$];
  logic [9:0]  mask_m = '0;
  logic        ovf_m = 1'b0;
  logic        iderr_m = 1'b0;
  logic [15:0] ts_m = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [3:0] id, input logic [1:0] code,
                       input logic rdy, input logic clr);
    @(posedge clock_fast);
    #1;
    output_valid     = v;
    processor_id_out = id;
    token_startstop  = code;
    evt_ready        = rdy;
    clear_flags      = clr;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 2'b00, rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clock_fast);
    #2;
    output_valid = 1'b0;
    token_startstop = 2'b00;
    evt_ready = 1'b0;
    clear_flags = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_evt_valid", evt_valid, 1'b0);
    chk("async_rst_fifo_count", fifo_count, 0);
    chk("async_rst_active_mask", active_mask, 0);
    @(posedge clock_fast);
    #1;
    reset = 1'b0;
  endtask

  // monitor + model: outputs are settled mid-cycle; the inputs seen here
  // are what the next rising edge will act on
  always @(negedge clock_fast) begin
    logic [21:0] head;
    logic ovf_set;
    logic id_set;
    if (reset) begin
      exp_q.delete();
      mask_m  = '0;
      ovf_m   = 1'b0;
      iderr_m = 1'b0;
      ts_m    = '0;
      chk("reset_evt_valid", evt_valid, 1'b0);
    end else begin
      chk("evt_valid", evt_valid, exp_q.size() != 0);
      chk("fifo_count", fifo_count, exp_q.size());
      chk("active_mask", active_mask, mask_m);
      chk("overflow", overflow, ovf_m);
      chk("id_error", id_error, iderr_m);
      head = (exp_q.size() != 0) ? exp_q[0] : '0;
      chk("head_id", evt_processor_id, head[21:18]);
      chk("head_code", evt_code, head[17:16]);
      chk("head_ts", evt_timestamp, head[15:0]);
      if (evt_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      ovf_set = 1'b0;
      id_set  = 1'b0;
      if (output_valid && token_startstop != 2'b00) begin
        if (processor_id_out < NP) begin
          if (exp_q.size() < FD) exp_q.push_back({processor_id_out, token_startstop, ts_m});
          else ovf_set = 1'b1;
          mask_m[processor_id_out] = (token_startstop != 2'b01);
        end else begin
          id_set = 1'b1;
        end
      end
      ovf_m   = ovf_set || (ovf_m && !clear_flags);
      iderr_m = id_set || (iderr_m && !clear_flags);
      ts_m    = ts_m + 16'd1;
    end
  end

  initial begin
    repeat (2) @(posedge clock_fast);
    #1;
    reset = 1'b0;

    // start then stop on id 2 at timestamps 3 and 5, host always ready
    idle(1'b1, 2);
    drive(1'b1, 4'd2, 2'b10, 1'b1, 1'b0);
    idle(1'b1, 1);
    drive(1'b1, 4'd2, 2'b01, 1'b1, 1'b0);
    idle(1'b1, 3);

    // nine starts into an eight-entry buffer, then capture+pop while full
    do_reset();
    for (int i = 0; i < 9; i++) drive(1'b1, 4'(i), 2'b10, 1'b0, 1'b0);
    idle(1'b0, 2);
    drive(1'b1, 4'd9, 2'b11, 1'b1, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 10);

    // out-of-range id, then clear; set-wins on a simultaneous clear
    drive(1'b1, 4'd12, 2'b10, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 2'b00, 1'b1, 1'b1);
    idle(1'b1, 1);
    drive(1'b1, 4'd15, 2'b01, 1'b1, 1'b0);
    drive(1'b1, 4'd11, 2'b10, 1'b1, 1'b1);
    idle(1'b1, 2);

    // reset with five events buffered
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 4'(i), 2'b10, 1'b0, 1'b0);
    do_reset();
    idle(1'b1, 2);

    // randomized traffic with alternating ready pressure
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] id;
      logic rdy;
      id  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      drive(1'($urandom_range(0, 1)), id, 2'($urandom_range(0, 3)), rdy,
            ($urandom_range(0, 15) == 0));
    end
    idle(1'b1, 12);

    // one capture at timestamp 4, held across a full counter wrap
    do_reset();
    idle(1'b0, 3);
    drive(1'b1, 4'd5, 2'b10, 1'b0, 1'b0);
    idle(1'b0, 65539);
    @(negedge clock_fast);
    chk("wrap_hold_ts", evt_timestamp, 16'd4);
    drive(1'b1, 4'd7, 2'b11, 1'b1, 1'b0);
    idle(1'b1, 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ttt_event_collector.md
TTT_EVENT_COLLECTOR -- requirements
Module: ttt_event_collector

Interface
REQ-001 SHALL have parameter NUM_PROCESSORS, default 10, number of processors in the core.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, event buffer entries (power of two, >=2).
REQ-003 SHALL have parameter TIMESTAMP_BITS, default 16, free-running timestamp width.
REQ-004 SHALL have port clock_fast, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port output_valid, input, 1, the core's event strobe.
REQ-007 SHALL have port processor_id_out, input, $clog2(NUM_PROCESSORS), the processor the event refers to.
REQ-008 SHALL have port token_startstop, input, 2, event code: 2'b10 start, 2'b01 stop, 2'b11 restart, 2'b00 none.
REQ-009 SHALL have port evt_valid, output, 1, head entry available.
REQ-010 SHALL have port evt_ready, input, 1, host accepts the head entry.
REQ-011 SHALL have port evt_processor_id, output, $clog2(NUM_PROCESSORS), head entry processor id.
REQ-012 SHALL have port evt_code, output, 2, head entry event code.
REQ-013 SHALL have port evt_timestamp, output, TIMESTAMP_BITS, head entry capture time.
REQ-014 SHALL have port active_mask, output, NUM_PROCESSORS, per-processor "currently active" bits.
REQ-015 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, occupied entries.
REQ-016 SHALL have port overflow, output, 1, sticky: event dropped due to full buffer.
REQ-017 SHALL have port id_error, output, 1, sticky: event with processor id >= NUM_PROCESSORS.
REQ-018 SHALL have port clear_flags, input, 1, synchronous clear of overflow and id_error.

Function
REQ-019 Timestamp counter SHALL increment by 1 every cycle and wrap from 2^TIMESTAMP_BITS-1 to 0.
REQ-020 Capture condition SHALL be output_valid=1, token_startstop!=2'b00 and processor_id_out<NUM_PROCESSORS.
REQ-021 A captured event SHALL store {processor id, code, timestamp value of the capture cycle}.
REQ-022 Output_valid=1 with id >= NUM_PROCESSORS and code!=00 SHALL be dropped, set id_error, and leave active_mask unchanged.
REQ-023 Output_valid=1 with code 2'b00 SHALL be ignored entirely.
REQ-024 Pop SHALL occur when evt_valid=1 and evt_ready=1; evt_ready while empty SHALL have no effect.
REQ-025 Push SHALL be accepted when fifo_count<FIFO_DEPTH, or when full and a pop occurs in the same cycle (count unchanged).
REQ-026 A capture with buffer full and no same-cycle pop SHALL be dropped and set overflow; active_mask SHALL still update.
REQ-027 evt_valid SHALL equal (fifo_count!=0); head fields SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-028 Latency: event captured at edge N SHALL be visible on evt_* after edge N (first-word fall-through, no extra bubble).
REQ-029 Events SHALL be delivered in capture order; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 active_mask bit SHALL set on code 10, clear on 01, be set on 11, updated at the capture edge.
REQ-031 Simultaneous clear_flags and a new flag condition SHALL leave the flag set (set wins).

Reset
REQ-032 Reset SHALL asynchronously force timestamp=0, pointers=0, fifo_count=0, evt_valid=0, active_mask=0, overflow=0, id_error=0.
REQ-033 evt_processor_id, evt_code, evt_timestamp SHALL read 0 while empty after reset; buffer contents need no reset.
REQ-034 Reset asserted mid-operation SHALL discard all buffered events; first capture after release timestamps from 0 upward.

Structure
REQ-035 Event code localparams (START, STOP, RESTART, NONE) and an event-record packed struct SHALL live in shared package ttt_pkg.
REQ-036 The buffer SHALL be one sub-module ttt_event_fifo (parameterised width/depth, push/pop/full/empty/count); capture, timestamp and mask logic stay in the top.

Verification
REQ-037 After reset, valid on cycles 3,5 with (id 2, 10),(id 2, 01), evt_ready=1 -> two events, timestamps 3 then 5, active_mask[2] high only between.
REQ-038 Nine starts on ids 0..8 in consecutive cycles with evt_ready=0 -> fifo_count=8, ninth dropped, overflow=1, active_mask=9'h1FF.
REQ-039 Buffer full, capture and pop in same cycle -> count stays 8, no overflow, new event appears last.
REQ-040 Valid with id 12 (NUM_PROCESSORS=10), code 10 -> no push, id_error=1; clear_flags next cycle -> 0.
REQ-041 Hold evt_ready=0 for 2^16+3 cycles after one capture at t=4 -> evt_timestamp stays 4 while counter wraps.
REQ-042 Assert reset with 5 events buffered -> evt_valid=0, count=0, active_mask=0 immediately, without a clock edge.
